// File: rtl/pos_avg_pkg.sv
// Shared types and helpers for the beam-position moving averager.
// Holds the control state encoding, the running-sum width rule and
// the window-size clamp shared by the top and its storage.
package pos_avg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    UPD  = 3'd2,
    SCAN = 3'd3,
    OUT  = 3'd4
  } state_e;

  // A boxcar of 2^log2_max_win samples grows the sum by log2_max_win bits.
  function automatic int sum_w(input int data_width, input int log2_max_win);
    return data_width + log2_max_win;
  endfunction

  // Limit the requested window exponent to what the buffer can hold.
  function automatic logic [2:0] clamp_win(input logic [2:0] req, input int log2_max_win);
    logic [2:0] lim;
    if (log2_max_win >= 7) begin
      return req;
    end
    lim = log2_max_win[2:0];
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/pos_avg_ram.sv
// Sample buffer for pos_avg: one write port and one synchronous read
// port, each {x,y,s} triple stored as a single word.
module pos_avg_ram #(
  parameter int WIDTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rd_data_q;

  // Write the new sample into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; data is valid the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pos_avg.sv
// Event-rate boxcar averager of beam X/Y/S over the last 2^log2_win events.
// Running sums are updated incrementally (add newest, drop oldest).
// Optional feature macro: POS_AVG_PKPK_EN adds a SCAN pass over the window
// producing X/Y peak-to-peak alongside each average update.
module pos_avg
  import pos_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_WIN = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         cal_flag,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [DATA_WIDTH-1:0] s_in,
  input  logic [2:0]                   log2_win,
  input  logic                         clr,
  output logic signed [DATA_WIDTH-1:0] x_avg,
  output logic signed [DATA_WIDTH-1:0] y_avg,
  output logic signed [DATA_WIDTH-1:0] s_avg,
  output logic                         avg_valid,
  output logic [LOG2_MAX_WIN:0]        fill_cnt,
  output logic                         win_full,
  output logic                         overrun
`ifdef POS_AVG_PKPK_EN
  ,
  output logic [DATA_WIDTH:0]          x_pkpk,
  output logic [DATA_WIDTH:0]          y_pkpk
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = LOG2_MAX_WIN;
  localparam int SW = sum_w(DATA_WIDTH, LOG2_MAX_WIN);
  localparam int MW = 3 * DATA_WIDTH;
  localparam logic [AW-1:0] PTR_TWO = AW'(2);

  // Floor average: arithmetic shift of the window sum, always fits DW bits.
  function automatic logic signed [DW-1:0] avg_of(input logic signed [SW-1:0] sum,
                                                   input logic [2:0] sh);
    logic signed [SW-1:0] t;
    t = sum >>> sh;
    return t[DW-1:0];
  endfunction

  state_e state_q, state_d;
  logic [2:0]           win_q, win_d, win_eff;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          fill_q, fill_d, fill_new, n_cur;
  logic                 full_cur, full_upd, accept, win_chg;
  logic signed [SW-1:0] sx_q, sx_d, sy_q, sy_d, ss_q, ss_d;
  logic signed [DW-1:0] xl_q, xl_d, yl_q, yl_d, sl_q, sl_d;
  logic signed [DW-1:0] xa_q, xa_d, ya_q, ya_d, sa_q, sa_d;
  logic                 ovr_q, ovr_d, vld_q, vld_d;
  logic                 ram_we, ram_re;
  logic [AW-1:0]        ram_waddr, ram_raddr;
  logic [MW-1:0]        ram_wdata, ram_rdata;
  logic signed [DW-1:0] old_x, old_y, old_s;

`ifdef POS_AVG_PKPK_EN
  // Peak-to-peak of a window, as an unsigned DW+1 bit span.
  function automatic logic [DW:0] span(input logic signed [DW-1:0] mx,
                                       input logic signed [DW-1:0] mn);
    logic signed [DW:0] d;
    d = {mx[DW-1], mx} - {mn[DW-1], mn};
    return d;
  endfunction

  logic [AW-1:0]        scan_q, scan_d;
  logic                 scan_last;
  logic signed [DW-1:0] xmn_q, xmn_d, xmx_q, xmx_d, ymn_q, ymn_d, ymx_q, ymx_d;
  logic [DW:0]          xpk_q, xpk_d, ypk_q, ypk_d;
`endif

  assign win_eff  = clamp_win(log2_win, AW);
  assign n_cur    = {{AW{1'b0}}, 1'b1} << win_q;
  assign full_cur = (fill_q == n_cur);
  assign fill_new = full_cur ? fill_q : fill_q + 1'b1;
  assign full_upd = (fill_new == n_cur);
  assign win_chg  = (state_q == IDLE) && (win_eff != win_q);
  assign accept   = (state_q == IDLE) && in_valid && !cal_flag && !clr;
  assign old_x    = ram_rdata[3*DW-1:2*DW];
  assign old_y    = ram_rdata[2*DW-1:DW];
  assign old_s    = ram_rdata[DW-1:0];
`ifdef POS_AVG_PKPK_EN
  assign scan_last = ({1'b0, scan_q} == (n_cur - 1'b1));
`endif

  pos_avg_ram #(
    .WIDTH (MW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // Next-state logic; clr aborts anything in flight.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = RD;
        RD:   state_d = UPD;
`ifdef POS_AVG_PKPK_EN
        UPD:  state_d = full_upd ? SCAN : OUT;
        SCAN: if (scan_last) state_d = OUT;
`else
        UPD:  state_d = OUT;
`endif
        OUT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer port control: fetch the leaving sample in RD, store the new one
  // in UPD, and walk the older window entries during SCAN.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = wr_ptr_q;
    ram_wdata = {xl_q, yl_q, sl_q};
    ram_raddr = wr_ptr_q - n_cur[AW-1:0];
    case (state_q)
      RD:  ram_re = 1'b1;
      UPD: ram_we = !clr;
`ifdef POS_AVG_PKPK_EN
      SCAN: begin
        ram_re    = 1'b1;
        ram_raddr = wr_ptr_q - PTR_TWO - scan_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath: window bookkeeping, running sums and output updates.
  always_comb begin
    win_d    = win_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ss_d     = ss_q;
    xl_d     = xl_q;
    yl_d     = yl_q;
    sl_d     = sl_q;
    xa_d     = xa_q;
    ya_d     = ya_q;
    sa_d     = sa_q;
    ovr_d    = ovr_q;
    vld_d    = 1'b0;
`ifdef POS_AVG_PKPK_EN
    scan_d   = scan_q;
    xmn_d    = xmn_q;
    xmx_d    = xmx_q;
    ymn_d    = ymn_q;
    ymx_d    = ymx_q;
    xpk_d    = xpk_q;
    ypk_d    = ypk_q;
`endif
    if (clr) begin
      sx_d     = '0;
      sy_d     = '0;
      ss_d     = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
      ovr_d    = 1'b0;
    end else begin
      if (in_valid && !cal_flag && (state_q != IDLE)) begin
        ovr_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          // A new window size starts from an empty window.
          if (win_chg) begin
            win_d    = win_eff;
            sx_d     = '0;
            sy_d     = '0;
            ss_d     = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
            ovr_d    = 1'b0;
          end
          if (accept) begin
            xl_d = x_in;
            yl_d = y_in;
            sl_d = s_in;
          end
        end
        UPD: begin
          if (full_cur) begin
            sx_d = sx_q + SW'(xl_q) - SW'(old_x);
            sy_d = sy_q + SW'(yl_q) - SW'(old_y);
            ss_d = ss_q + SW'(sl_q) - SW'(old_s);
          end else begin
            sx_d = sx_q + SW'(xl_q);
            sy_d = sy_q + SW'(yl_q);
            ss_d = ss_q + SW'(sl_q);
          end
          fill_d   = fill_new;
          wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef POS_AVG_PKPK_EN
          // The newest sample seeds min/max; SCAN folds in the rest.
          xmn_d  = xl_q;
          xmx_d  = xl_q;
          ymn_d  = yl_q;
          ymx_d  = yl_q;
          scan_d = '0;
`else
          if (full_upd) begin
            xa_d  = avg_of(sx_d, win_q);
            ya_d  = avg_of(sy_d, win_q);
            sa_d  = avg_of(ss_d, win_q);
            vld_d = 1'b1;
          end
`endif
        end
`ifdef POS_AVG_PKPK_EN
        SCAN: begin
          // Read data lags the address by one cycle, so cycle 0 has none.
          if (scan_q != '0) begin
            if (old_x < xmn_q) xmn_d = old_x;
            if (old_x > xmx_q) xmx_d = old_x;
            if (old_y < ymn_q) ymn_d = old_y;
            if (old_y > ymx_q) ymx_d = old_y;
          end
          scan_d = scan_q + 1'b1;
          if (scan_last) begin
            xa_d  = avg_of(sx_q, win_q);
            ya_d  = avg_of(sy_q, win_q);
            sa_d  = avg_of(ss_q, win_q);
            xpk_d = span(xmx_d, xmn_d);
            ypk_d = span(ymx_d, ymn_d);
            vld_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      ss_q     <= '0;
      xa_q     <= '0;
      ya_q     <= '0;
      sa_q     <= '0;
      ovr_q    <= 1'b0;
      vld_q    <= 1'b0;
`ifdef POS_AVG_PKPK_EN
      xpk_q    <= '0;
      ypk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      ss_q     <= ss_d;
      xa_q     <= xa_d;
      ya_q     <= ya_d;
      sa_q     <= sa_d;
      ovr_q    <= ovr_d;
      vld_q    <= vld_d;
`ifdef POS_AVG_PKPK_EN
      xpk_q    <= xpk_d;
      ypk_q    <= ypk_d;
`endif
    end
  end

  // Sample latch and scan working registers; no reset needed.
  always_ff @(posedge clk) begin
    xl_q  <= xl_d;
    yl_q  <= yl_d;
    sl_q  <= sl_d;
`ifdef POS_AVG_PKPK_EN
    scan_q <= scan_d;
    xmn_q  <= xmn_d;
    xmx_q  <= xmx_d;
    ymn_q  <= ymn_d;
    ymx_q  <= ymx_d;
`endif
  end

  assign x_avg     = xa_q;
  assign y_avg     = ya_q;
  assign s_avg     = sa_q;
  assign avg_valid = vld_q;
  assign fill_cnt  = fill_q;
  assign win_full  = full_cur;
  assign overrun   = ovr_q;
`ifdef POS_AVG_PKPK_EN
  assign x_pkpk    = xpk_q;
  assign y_pkpk    = ypk_q;
`endif

endmodule

// File: tb/tb_pos_avg.sv
// Self-checking bench for pos_avg: a queue-based window model predicts
// every averages update; directed sequences pin literal values.
module tb_pos_avg;

  localparam int DW = 16;
  localparam int AW = 6;
`ifdef POS_AVG_PKPK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, cal_flag, clr;
  logic signed [DW-1:0] x_in, y_in, s_in;
  logic [2:0] log2_win;
  logic signed [DW-1:0] x_avg, y_avg, s_avg;
  logic avg_valid, win_full, overrun;
  logic [AW:0] fill_cnt;
`ifdef POS_AVG_PKPK_EN
  logic [DW:0] x_pkpk, y_pkpk;
`endif

  pos_avg #(.DATA_WIDTH(DW), .LOG2_MAX_WIN(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cal_flag(cal_flag),
    .x_in(x_in), .y_in(y_in), .s_in(s_in), .log2_win(log2_win), .clr(clr),
    .x_avg(x_avg), .y_avg(y_avg), .s_avg(s_avg), .avg_valid(avg_valid),
    .fill_cnt(fill_cnt), .win_full(win_full), .overrun(overrun)
`ifdef POS_AVG_PKPK_EN
    , .x_pkpk(x_pkpk), .y_pkpk(y_pkpk)
`endif
  );

  always #5 clk = ~clk;

  // Model state
  int qx[$], qy[$], qs[$];
  int n_win;
  bit m_ovr;
  int cyc, exp_cyc;
  longint ex_x, ex_y, ex_s, ex_xpk, ex_ypk;
  bit run;
  int checks, failures;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint n);
    if (a >= 0) return a / n;
    return -((-a + n - 1) / n);
  endfunction

  task automatic model_clear();
    qx.delete(); qy.delete(); qs.delete();
    m_ovr = 1'b0;
    exp_cyc = -1;
  endtask

  task automatic model_accept(input int x, input int y, input int s, output int extra);
    longint sx, sy, ss;
    int mnx, mxx, mny, mxy;
    qx.push_back(x); qy.push_back(y); qs.push_back(s);
    if (qx.size() > n_win) begin
      qx.delete(0); qy.delete(0); qs.delete(0);
    end
    extra = 0;
    if (qx.size() == n_win) begin
      sx = 0; sy = 0; ss = 0;
      mnx = qx[0]; mxx = qx[0]; mny = qy[0]; mxy = qy[0];
      for (int i = 0; i < qx.size(); i++) begin
        sx += qx[i]; sy += qy[i]; ss += qs[i];
        if (qx[i] < mnx) mnx = qx[i];
        if (qx[i] > mxx) mxx = qx[i];
        if (qy[i] < mny) mny = qy[i];
        if (qy[i] > mxy) mxy = qy[i];
      end
      ex_x = fdiv(sx, n_win);
      ex_y = fdiv(sy, n_win);
      ex_s = fdiv(ss, n_win);
      ex_xpk = mxx - mnx;
      ex_ypk = mxy - mny;
      extra = PK ? n_win : 0;
      exp_cyc = cyc + 3 + extra;
    end
  endtask

  task automatic send(input int x, input int y, input int s, input bit cal, input int spacing);
    int extra;
    int k;
    @(negedge clk);
    x_in = x[DW-1:0]; y_in = y[DW-1:0]; s_in = s[DW-1:0];
    cal_flag = cal; in_valid = 1'b1;
    extra = 0;
    if (!cal) model_accept(x, y, s, extra);
    @(negedge clk);
    in_valid = 1'b0; cal_flag = 1'b0;
    k = 3 + extra;
    if (spacing - 1 > k) k = spacing - 1;
    repeat (k) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_win(input int w);
    int nn;
    @(negedge clk);
    log2_win = w[2:0];
    nn = 1 << ((w > AW) ? AW : w);
    if (nn != n_win) begin
      n_win = nn;
      model_clear();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_fill"}, fill_cnt, qx.size());
    chk({tag, "_full"}, win_full, qx.size() == n_win);
    chk({tag, "_ovr"}, overrun, m_ovr);
  endtask

  initial begin
    int r1, r2, r3, last_x;
    int dummy;
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; cal_flag = 1'b0; clr = 1'b0;
    x_in = '0; y_in = '0; s_in = '0; log2_win = 3'd2;
    n_win = 4; m_ovr = 1'b0; cyc = 0; exp_cyc = -1; run = 1'b0;

    // Per-cycle comparison against the model
    fork
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (run) begin
          chk("avg_valid", avg_valid, (cyc == exp_cyc));
          if (cyc == exp_cyc) begin
            chk("x_avg", x_avg, ex_x);
            chk("y_avg", y_avg, ex_y);
            chk("s_avg", s_avg, ex_s);
`ifdef POS_AVG_PKPK_EN
            chk("x_pkpk", x_pkpk, ex_xpk);
            chk("y_pkpk", y_pkpk, ex_ypk);
`endif
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_full", win_full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_x_avg", x_avg, 0);
    chk("rst_y_avg", y_avg, 0);
    chk("rst_s_avg", s_avg, 0);
    run = 1'b1;

    // Fill window of 4, then slide by one
    send(100, 0, 0, 1'b0, 10);
    send(200, 0, 0, 1'b0, 10);
    send(300, 0, 0, 1'b0, 10);
    chk("fill3_full", win_full, 0);
    send(400, 0, 0, 1'b0, 10);
    chk("lit_x250", x_avg, 250);
    chk("lit_full4", win_full, 1);
    chk("lit_fill4", fill_cnt, 4);
    send(500, 0, 0, 1'b0, 10);
    chk("lit_x350", x_avg, 350);

    // Negative values round toward minus infinity
    do_clr();
    send(-1, 10, -3, 1'b0, 0);
    send(-2, 20, -3, 1'b0, 0);
    send(-2, 30, -3, 1'b0, 0);
    send(-2, 41, -4, 1'b0, 0);
    chk("lit_xneg", x_avg, -2);
    chk("lit_y25", y_avg, 25);
    chk("lit_sneg", s_avg, -4);

    // Peak-to-peak window
    do_clr();
    send(1, -5, 0, 1'b0, 0);
    send(2, 7, 0, 1'b0, 0);
    send(3, 0, 0, 1'b0, 0);
    send(4, 3, 0, 1'b0, 0);
    chk("lit_y_avg1", y_avg, 1);
`ifdef POS_AVG_PKPK_EN
    chk("lit_ypk12", y_pkpk, 12);
    chk("lit_xpk3", x_pkpk, 3);
`endif

    // Overrun: second sample two cycles after the first
    do_clr();
    @(negedge clk);
    x_in = 16'sd7; y_in = '0; s_in = '0; in_valid = 1'b1;
    model_accept(7, 0, 0, dummy);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    x_in = 16'sd9; in_valid = 1'b1;
    m_ovr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_fill1", fill_cnt, 1);
    do_clr();
    chk("clr_ovr", overrun, 0);
    chk("clr_fill", fill_cnt, 0);

    // clr beats a same-cycle in_valid
    @(negedge clk);
    in_valid = 1'b1; clr = 1'b1;
    model_clear();
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    repeat (4) @(negedge clk);
    chk_status("clr_prio");

    // Calibration events are ignored; window change empties
    for (int i = 0; i < 4; i++) send(10 * i, -i, i, 1'b0, 0);
    send(9999, 9999, 9999, 1'b1, 0);
    chk("cal_fill", fill_cnt, 4);
    chk_status("cal");
    set_win(3);
    chk("winchg_fill", fill_cnt, 0);
    chk("winchg_full", win_full, 0);

    // Window of one follows the latest sample
    set_win(0);
    for (int i = 0; i < 3; i++) begin
      last_x = -123 + 50 * i;
      send(last_x, i, -i, 1'b0, 0);
    end
    chk("lit_n1", x_avg, last_x);
    chk_status("n1");

    // clr in the middle of an update: no avg_valid, outputs held
    @(negedge clk);
    x_in = 16'sd555; in_valid = 1'b1;
    model_accept(555, 0, 0, dummy);
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_fill", fill_cnt, 0);
    chk("abort_hold", x_avg, last_x);

    // Full-size window with random data, across pointer wrap
    set_win(6);
    for (int i = 0; i < 264; i++) begin
      r1 = int'($urandom_range(65534, 0)) - 32767;
      r2 = int'($urandom_range(65534, 0)) - 32767;
      r3 = int'($urandom_range(65534, 0)) - 32767;
      send(r1, r2, r3, 1'b0, 0);
    end
    chk_status("rand64");

    // Request above the maximum clamps to the same window: no reset of it
    set_win(7);
    chk("clamp_fill", fill_cnt, 64);
    for (int i = 0; i < 10; i++) begin
      r1 = int'($urandom_range(65534, 0)) - 32767;
      r2 = int'($urandom_range(65534, 0)) - 32767;
      r3 = int'($urandom_range(65534, 0)) - 32767;
      send(r1, r2, r3, 1'b0, 0);
    end
    chk_status("clamp");

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pos_avg.md
# pos_avg

Event-rate moving averager for beam position, downstream of the position calculator in the signal-processing chain. It consumes one X/Y/S triple per real (non-calibration) event and keeps a boxcar window of the last 2^k events. Each update produces windowed averages of X, Y and S for the slow-FIFO packer and the MB register map. The running sums are updated incrementally: add the new sample, subtract the one leaving the window.

## Interface
Parameters:
- DATA_WIDTH, 16, width of the signed two's-complement X/Y/S samples
- LOG2_MAX_WIN, 6, log2 of the maximum window depth (64 events); sets the buffer depth

Ports:
- clk  in  1  processing clock (10 MHz domain)
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  one-clk pulse, new position sample present
- cal_flag  in  1  current event is a calibration event; sample ignored
- x_in, y_in, s_in  in  DATA_WIDTH each  signed samples
- log2_win  in  3  requested window = 2^log2_win; values above LOG2_MAX_WIN are clamped
- clr  in  1  one-clk pulse, empties the window
- x_avg, y_avg, s_avg  out  DATA_WIDTH each  signed averages
- avg_valid  out  1  one-clk pulse, averages updated
- fill_cnt  out  LOG2_MAX_WIN+1  number of samples currently in the window
- win_full  out  1  fill_cnt == 2^log2_win (effective value)
- overrun  out  1  sticky: a sample was dropped because the block was busy
- x_pkpk, y_pkpk  out  DATA_WIDTH+1 each  window peak-to-peak (only when POS_AVG_PKPK_EN is defined)

## Operation
- **Storage and sums:** the buffer is 2^LOG2_MAX_WIN entries of {x,y,s}. wr_ptr is LOG2_MAX_WIN bits and wraps modulo the depth. Sums are signed, DATA_WIDTH+LOG2_MAX_WIN bits wide, and never overflow.
- **Accepted sample:** in_valid=1, cal_flag=0, state IDLE.
  - The inputs are latched.
  - The entry at (wr_ptr − N) mod depth is read, where N = 2^log2_win.
  - If win_full: sum ← sum + new − old. Otherwise: sum ← sum + new, and fill_cnt increments.
  - The new sample is written at wr_ptr, then wr_ptr increments.
- **Averages:** avg = sum >>> log2_win, an arithmetic shift that rounds toward −∞. The result is truncated to DATA_WIDTH; it always fits.
- **Output gating:** avg_valid pulses and the averages update only if win_full is true after the update. While the window is filling, the outputs hold their previous values.
- **cal_flag=1 with in_valid:** the sample is ignored entirely. There is no overrun and no count change.
- **in_valid outside IDLE:** the sample is dropped and overrun is set.
- **Window change:** log2_win is latched into win_reg in IDLE. If the clamped value differs from win_reg, the block performs an implicit clr before accepting the next sample.
- **clr** clears sums, fill_cnt, wr_ptr and overrun, and aborts any in-flight update. Buffer contents are left untouched. clr has priority over a same-cycle in_valid, which is discarded and does not set overrun.
- **State machine:**
  - IDLE → RD on an accepted sample.
  - RD (synchronous buffer read) → UPD.
  - UPD (sum update, buffer write, pointer/count update) → OUT, or → SCAN when the macro is defined and win_full.
  - SCAN → OUT.
  - OUT (registered outputs, avg_valid pulse) → IDLE.
- log2_win = 0: N = 1. The window is full after the first sample, and avg equals the latest sample.

## Timing
- Reset and clr: all outputs 0, state IDLE. (clr leaves the average and peak-to-peak outputs unchanged.)
- Accepted in_valid at cycle T: RD at T+1, UPD at T+2, OUT at T+3. avg_valid is high during T+3, with averages stable from T+3.
- The block is back in IDLE at T+4, so the minimum accepted input spacing is 4 cycles. Any in_valid at T+1..T+3 sets overrun.
- With POS_AVG_PKPK_EN and win_full: SCAN takes N cycles, so avg_valid arrives at T+3+N and the next sample is accepted from T+4+N.
- A reset or clr asserted mid-operation returns the block to IDLE on the next edge, with no avg_valid.

## Configuration
- POS_AVG_PKPK_EN defined: SCAN reads the N most recent entries, one per cycle, tracking min and max of X and Y.
  - x_pkpk = max − min, computed at DATA_WIDTH+1 bits unsigned, and likewise y_pkpk.
  - Both are updated together with avg_valid.
- POS_AVG_PKPK_EN undefined: the x_pkpk and y_pkpk ports and all SCAN logic are absent. The OUT-state latency is fixed at 3 cycles.

## Structure
- Shared package pos_avg_pkg contains:
  - the state enum (IDLE, RD, UPD, SCAN, OUT);
  - the SUM_W = DATA_WIDTH+LOG2_MAX_WIN constant function;
  - the clamp function for log2_win.
- One sub-module, pos_avg_ram: single write port, synchronous-read memory, 3*DATA_WIDTH wide, 2^LOG2_MAX_WIN deep. It holds the entire sample buffer, which is written in UPD and read in RD and SCAN.

## Test plan
- log2_win=2, X inputs 100, 200, 300, 400 spaced 10 cycles apart → no avg_valid for the first three; after the 4th, x_avg = 250 at T+3 and win_full = 1. A 5th input X = 500 → x_avg = 350.
- log2_win=2, X inputs −1, −2, −2, −2 → x_avg = −2 (−7 >>> 2); S and Y are checked independently with distinct values.
- in_valid at T and T+2 → the second sample is dropped, overrun = 1, and fill_cnt = 1. A subsequent clr → overrun = 0 and fill_cnt = 0.
- in_valid with cal_flag=1 → fill_cnt is unchanged and there is no avg_valid. Changing log2_win from 2 to 3 after the window is full → fill_cnt = 0 and win_full = 0.
- Fill a 64-event window (log2_win=6) and continue for 200 events with random ±32767 data → averages match a software reference model exactly, including across wr_ptr wrap-around.
- With POS_AVG_PKPK_EN, log2_win=2, Y inputs −5, 7, 0, 3 → y_pkpk = 12, and avg_valid arrives at T+7.
